// File: rtl/opseq_pkg.sv
// opseq_pkg: shared types and default sizing for operand_sequencer.
//   state_t     - sequencer FSM states (IDLE, ISSUE, WAIT, WB)
//   OP_ADD/SUB  - opcode encoding forwarded to processor.operation_in
//   *_DEF       - default WORDSIZE / SIZE / EXEC_CYCLES
package opseq_pkg;

  localparam int unsigned WORDSIZE_DEF    = 64;
  localparam int unsigned SIZE_DEF        = 32;
  localparam int unsigned EXEC_CYCLES_DEF = 1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/opseq_regfile.sv
// opseq_regfile: SIZE x WORDSIZE register bank, cleared asynchronously by reset.
//   clk, reset                     - clock, async active-high clear
//   op_a_addr/op_b_addr -> op_*    - combinational operand read port (rs1, rs2)
//   host_rd_addr -> host_rd_data   - combinational host read port
//   wb_en/wb_addr/wb_data          - writeback port (has priority)
//   host_wr_en/addr/data           - host write port
module opseq_regfile
  import opseq_pkg::*;
#(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned SIZE     = SIZE_DEF,
  localparam int unsigned AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       op_a_addr,
  input  logic [AW-1:0]       op_b_addr,
  output logic [WORDSIZE-1:0] op_a_data,
  output logic [WORDSIZE-1:0] op_b_data,
  input  logic [AW-1:0]       host_rd_addr,
  output logic [WORDSIZE-1:0] host_rd_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [WORDSIZE-1:0] wb_data,
  input  logic                host_wr_en,
  input  logic [AW-1:0]       host_wr_addr,
  input  logic [WORDSIZE-1:0] host_wr_data
);

  logic [WORDSIZE-1:0] mem [SIZE];

  assign op_a_data    = mem[op_a_addr];
  assign op_b_data    = mem[op_b_addr];
  assign host_rd_data = mem[host_rd_addr];

  // Per-entry write select; writeback beats a same-index host write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          mem[i] <= wb_data;
        end else if (host_wr_en && (host_wr_addr == AW'(i))) begin
          mem[i] <= host_wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: drives the combinational processor datapath from a
// register bank, executing rd <- rs1 op rs2 commands one at a time.
//   clk, reset                    - clock, async active-high reset
//   cmd_valid/cmd_ready           - command handshake (ready only in IDLE)
//   cmd_op, cmd_rs1/rs2/rd        - opcode and register indices
//   wr_en/wr_addr/wr_data         - host write port (honored in every state)
//   rd_addr/rd_data               - combinational host read port
//   num1/num2/operation_in        - registered operands to processor
//   result                        - processor output
//   done/done_data                - one-cycle completion pulse and written value
//   check_err                     - only with OPSEQ_SELFCHECK_EN: result mismatch
//                                   against an internal recomputation
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned WORDSIZE    = WORDSIZE_DEF,
  parameter int unsigned SIZE        = SIZE_DEF,
  parameter int unsigned EXEC_CYCLES = EXEC_CYCLES_DEF,
  localparam int unsigned AW         = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [AW-1:0]       cmd_rs1,
  input  logic [AW-1:0]       cmd_rs2,
  input  logic [AW-1:0]       cmd_rd,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WORDSIZE-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [WORDSIZE-1:0] rd_data,
  output logic [WORDSIZE-1:0] num1,
  output logic [WORDSIZE-1:0] num2,
  output logic                operation_in,
  input  logic [WORDSIZE-1:0] result,
`ifdef OPSEQ_SELFCHECK_EN
  output logic                check_err,
`endif
  output logic                done,
  output logic [WORDSIZE-1:0] done_data
);

  localparam int unsigned CW = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES + 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                op_q, op_nxt;
  logic [AW-1:0]       rs1_q, rs1_nxt;
  logic [AW-1:0]       rs2_q, rs2_nxt;
  logic [AW-1:0]       rd_q, rd_nxt;
  logic [WORDSIZE-1:0] num1_nxt, num2_nxt;
  logic                operation_nxt;
  logic                done_nxt;
  logic [WORDSIZE-1:0] done_data_nxt;
  logic                wb_en;
  logic [WORDSIZE-1:0] op_a_data, op_b_data;

  assign cmd_ready = (state == IDLE);

  opseq_regfile #(
    .WORDSIZE (WORDSIZE),
    .SIZE     (SIZE)
  ) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .op_a_addr    (rs1_q),
    .op_b_addr    (rs2_q),
    .op_a_data    (op_a_data),
    .op_b_data    (op_b_data),
    .host_rd_addr (rd_addr),
    .host_rd_data (rd_data),
    .wb_en        (wb_en),
    .wb_addr      (rd_q),
    .wb_data      (result),
    .host_wr_en   (wr_en),
    .host_wr_addr (wr_addr),
    .host_wr_data (wr_data)
  );

  // Next-state and datapath control.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_nxt        = op_q;
    rs1_nxt       = rs1_q;
    rs2_nxt       = rs2_q;
    rd_nxt        = rd_q;
    num1_nxt      = num1;
    num2_nxt      = num2;
    operation_nxt = operation_in;
    done_nxt      = 1'b0;
    done_data_nxt = done_data;
    wb_en         = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_nxt    = cmd_op;
          rs1_nxt   = cmd_rs1;
          rs2_nxt   = cmd_rs2;
          rd_nxt    = cmd_rd;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Operands read here, so a host write on the accept edge is seen.
        num1_nxt      = op_a_data;
        num2_nxt      = op_b_data;
        operation_nxt = op_q;
        cnt_nxt       = CW'(EXEC_CYCLES);
        state_nxt     = WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = WB;
        end
      end
      WB: begin
        wb_en         = 1'b1;
        done_nxt      = 1'b1;
        done_data_nxt = result;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef OPSEQ_SELFCHECK_EN
  // Recompute from the operands captured in ISSUE and flag disagreement.
  logic [WORDSIZE-1:0] expected_c;
  logic                check_err_nxt;

  always_comb begin
    expected_c    = (operation_in == OP_SUB) ? (num1 - num2) : (num1 + num2);
    check_err_nxt = (state == WB) && (expected_c != result);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_err <= 1'b0;
    end else begin
      check_err <= check_err_nxt;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= OP_ADD;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      num1         <= '0;
      num2         <= '0;
      operation_in <= OP_ADD;
      done         <= 1'b0;
      done_data    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      op_q         <= op_nxt;
      rs1_q        <= rs1_nxt;
      rs2_q        <= rs2_nxt;
      rd_q         <= rd_nxt;
      num1         <= num1_nxt;
      num2         <= num2_nxt;
      operation_in <= operation_nxt;
      done         <= done_nxt;
      done_data    <= done_data_nxt;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed bench for operand_sequencer with a
// behavioural processor stub (add/sub, optional forced-zero fault).
// Covers OPSEQ_SELFCHECK_EN checks when that macro is defined.
module tb_operand_sequencer;

  localparam int unsigned WS = 64;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WS-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [WS-1:0] rd_data;
  logic [WS-1:0] num1, num2;
  logic          operation_in;
  logic [WS-1:0] result;
  logic          done;
  logic [WS-1:0] done_data;
`ifdef OPSEQ_SELFCHECK_EN
  logic          check_err;
`endif

  logic force_zero;
  int   checks;
  int   errors;

  operand_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_rd       (cmd_rd),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .num1         (num1),
    .num2         (num2),
    .operation_in (operation_in),
    .result       (result),
`ifdef OPSEQ_SELFCHECK_EN
    .check_err    (check_err),
`endif
    .done         (done),
    .done_data    (done_data)
  );

  // Processor stub: add/sub modulo 2^64, or a forced-zero fault.
  always_comb begin
    if (force_zero) result = '0;
    else if (operation_in) result = num1 - num2;
    else result = num1 + num2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [WS-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [AW-1:0] a, input logic [WS-1:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Issue one command, wait (bounded) for done, check latency and result.
  task automatic run_cmd(input string tag, input logic op, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [AW-1:0] d,
                         input logic [WS-1:0] exp);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = a; cmd_rs2 = b; cmd_rd = d;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, WS'(n), WS'(3));
    chk({tag, "_data"}, done_data, exp);
    peek({tag, "_bank"}, d, exp);
  endtask

  initial begin
    int dones;
    checks = 0; errors = 0;
    force_zero = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", WS'(cmd_ready), WS'(1));
    chk("rst_done", WS'(done), WS'(0));
    chk("rst_num1", num1, '0);
    chk("rst_done_data", done_data, '0);
`ifdef OPSEQ_SELFCHECK_EN
    chk("rst_check_err", WS'(check_err), WS'(0));
`endif
    peek("rst_bank0", 5'd0, '0);

    // Basic add, with per-cycle timing of the first command
    host_write(5'd1, 64'h5);
    host_write(5'd2, 64'h2);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd3;
    tick();
    cmd_valid = 1'b0;
    chk("t1_ready_drop", WS'(cmd_ready), WS'(0));
    tick();
    chk("t1_num1", num1, 64'h5);
    chk("t1_num2", num2, 64'h2);
    chk("t1_done_e1", WS'(done), WS'(0));
    tick();
    chk("t1_done_e2", WS'(done), WS'(0));
    tick();
    chk("t1_done", WS'(done), WS'(1));
    chk("t1_ready_rise", WS'(cmd_ready), WS'(1));
    chk("t1_data", done_data, 64'h7);
    peek("t1_bank3", 5'd3, 64'h7);
    tick();
    chk("t1_done_pulse", WS'(done), WS'(0));

    // Wider operands, subtraction wrap, aliasing
    host_write(5'd4, 64'h5000a);
    host_write(5'd5, 64'h2);
    run_cmd("add46", 1'b0, 5'd4, 5'd5, 5'd6, 64'h5000c);
    host_write(5'd7, 64'h10005);
    host_write(5'd8, 64'h2_0000_0000);
    run_cmd("add79", 1'b0, 5'd7, 5'd8, 5'd9, 64'h0000_0002_0001_0005);
    run_cmd("sub_wrap", 1'b1, 5'd2, 5'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD);
    run_cmd("alias", 1'b0, 5'd1, 5'd1, 5'd1, 64'hA);
    chk("alias_op_reg", num1, 64'h5);

    // Back-to-back with cmd_valid held high
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rs1 = 5'd4; cmd_rs2 = 5'd5; cmd_rd = 5'd11;
    tick();
    cmd_op = 1'b1; cmd_rs1 = 5'd9; cmd_rs2 = 5'd7; cmd_rd = 5'd12;
    tick(); tick(); tick();
    chk("b2b_done_a", WS'(done), WS'(1));
    chk("b2b_data_a", done_data, 64'h5000c);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_accept_b", WS'(cmd_ready), WS'(0));
    tick(); tick(); tick();
    chk("b2b_done_b", WS'(done), WS'(1));
    chk("b2b_data_b", done_data, 64'h2_0000_0000);
    peek("b2b_bank11", 5'd11, 64'h5000c);

    // cmd_valid pulses while busy produce no extra command
    tick();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd13;
    tick();
    cmd_rd = 5'd14;
    tick(); tick();
    cmd_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    chk("busy_done_count", WS'(dones), WS'(1));
    peek("busy_bank13", 5'd13, 64'hC);
    peek("busy_bank14", 5'd14, '0);

    // Host write to rd on the WB edge, plus a different-index write
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rs1 = 5'd4; cmd_rs2 = 5'd5; cmd_rd = 5'd14;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    host_write(5'd14, 64'hDEAD);
    chk("wbcol_done", WS'(done), WS'(1));
    peek("wbcol_bank14", 5'd14, 64'h5000c);
    cmd_valid = 1'b1; cmd_rd = 5'd16;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    host_write(5'd15, 64'hBEEF);
    peek("wbdiff_bank16", 5'd16, 64'h5000c);
    peek("wbdiff_bank15", 5'd15, 64'hBEEF);

    // Host write to rs1 on the accept edge is used as the operand
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h100;
    run_cmd("acc_write", 1'b0, 5'd2, 5'd2, 5'd17, 64'h200);
    wr_en = 1'b0;

    // Reset during WAIT aborts the command
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_done", WS'(done), WS'(0));
    chk("abort_num1", num1, '0);
    chk("abort_num2", num2, '0);
    chk("abort_op", WS'(operation_in), WS'(0));
    chk("abort_done_data", done_data, '0);
    chk("abort_ready", WS'(cmd_ready), WS'(1));
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", WS'(dones), WS'(0));
    peek("abort_bank3", 5'd3, '0);
    peek("abort_bank1", 5'd1, '0);

`ifdef OPSEQ_SELFCHECK_EN
    host_write(5'd5, 64'h5);
    host_write(5'd6, 64'h2);
    force_zero = 1'b1;
    run_cmd("sc_bad", 1'b0, 5'd5, 5'd6, 5'd7, 64'h0);
    chk("sc_bad_err", WS'(check_err), WS'(1));
    force_zero = 1'b0;
    tick();
    chk("sc_err_pulse", WS'(check_err), WS'(0));
    run_cmd("sc_good", 1'b0, 5'd5, 5'd6, 5'd7, 64'h7);
    chk("sc_good_err", WS'(check_err), WS'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
